// File: rtl/gps_gen_pkg.sv
// gps_gen_pkg: shared constants, PRN tap table, LFSR step and channel state type for the C/A generator.
package gps_gen_pkg;
  localparam int CHIP_LEN = 1023;
  localparam logic [9:0] G1_TAPS = 10'h204;
  localparam logic [9:0] G2_TAPS = 10'h3a6;
  typedef enum logic [1:0] {ST_IDLE, ST_SEEK, ST_RUN} chan_st_e;
  typedef struct packed {
    logic [3:0] s1;
    logic [3:0] s2;
  } taps_t;
  // Bit k holds stage k+1; the feedback enters stage 1 and stage 10 is the output.
  function automatic logic [9:0] lfsr_step(input logic [9:0] g, input logic [9:0] taps);
    return {g[8:0], ^(g & taps)};
  endfunction
  // G2 phase-selector taps per PRN, zero-based stage indices.
  function automatic taps_t prn_taps(input logic [4:0] sel);
    logic [7:0] t;
    case (sel)
      5'd0:  t = 8'h15;
      5'd1:  t = 8'h26;
      5'd2:  t = 8'h37;
      5'd3:  t = 8'h48;
      5'd4:  t = 8'h08;
      5'd5:  t = 8'h19;
      5'd6:  t = 8'h07;
      5'd7:  t = 8'h18;
      5'd8:  t = 8'h29;
      5'd9:  t = 8'h12;
      5'd10: t = 8'h23;
      5'd11: t = 8'h45;
      5'd12: t = 8'h56;
      5'd13: t = 8'h67;
      5'd14: t = 8'h78;
      5'd15: t = 8'h89;
      5'd16: t = 8'h03;
      5'd17: t = 8'h14;
      5'd18: t = 8'h25;
      5'd19: t = 8'h36;
      5'd20: t = 8'h47;
      5'd21: t = 8'h58;
      5'd22: t = 8'h02;
      5'd23: t = 8'h35;
      5'd24: t = 8'h46;
      5'd25: t = 8'h57;
      5'd26: t = 8'h68;
      5'd27: t = 8'h79;
      5'd28: t = 8'h05;
      5'd29: t = 8'h16;
      5'd30: t = 8'h27;
      default: t = 8'h38;
    endcase
    return taps_t'(t);
  endfunction
endpackage

// File: rtl/gps_ca_chan.sv
// gps_ca_chan: one C/A channel; seeks to a captured code phase at clock rate, then steps on chip strobes.
module gps_ca_chan
  import gps_gen_pkg::*;
#(
  parameter int PHASE_W  = 16,
  parameter int SAT_W    = 5,
  parameter int CHIP_LEN = gps_gen_pkg::CHIP_LEN
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               ena_in,
  input  logic               start_in,
  input  logic               en_in,
  input  logic [SAT_W-1:0]   sat_sel_in,
  input  logic [PHASE_W-1:0] phase_in,
  output logic               gc_out,
  output logic               epoch_out,
  output logic               done_out,
  output logic               seek_out
);
  localparam logic [9:0] LAST = 10'(CHIP_LEN - 1);
  chan_st_e st_q, st_d;
  logic [9:0] g1_q, g1_d, g2_q, g2_d, idx_q, idx_d;
  logic [PHASE_W-1:0] cnt_q, cnt_d, phase_q, phase_d;
  taps_t taps_q, taps_d;
  logic epoch_q, epoch_d, adv;
  always_comb begin
    st_d = st_q;
    g1_d = g1_q;
    g2_d = g2_q;
    idx_d = idx_q;
    cnt_d = cnt_q;
    phase_d = phase_q;
    taps_d = taps_q;
    epoch_d = 1'b0;
    adv = 1'b0;
    if (!en_in) begin
      st_d = ST_IDLE;
      g1_d = '1;
      g2_d = '1;
      idx_d = '0;
      cnt_d = '0;
      phase_d = '0;
      taps_d = '0;
    end else if (start_in) begin
      st_d = (phase_in != '0) ? ST_SEEK : ST_RUN;
      g1_d = '1;
      g2_d = '1;
      idx_d = '0;
      cnt_d = '0;
      phase_d = phase_in;
      taps_d = prn_taps(sat_sel_in);
    end else begin
      adv = (st_q == ST_SEEK) || (st_q == ST_RUN && ena_in);
      if (adv) begin
        g1_d = lfsr_step(g1_q, G1_TAPS);
        g2_d = lfsr_step(g2_q, G2_TAPS);
        idx_d = (idx_q == LAST) ? 10'd0 : idx_q + 10'd1;
        epoch_d = (idx_q == LAST);
      end
      // The seek ends on the advance that completes `phase` steps.
      if (st_q == ST_SEEK) begin
        cnt_d = cnt_q + 1'b1;
        st_d = (cnt_q == phase_q - 1'b1) ? ST_RUN : ST_SEEK;
      end
    end
  end
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      st_q <= ST_IDLE;
      g1_q <= '1;
      g2_q <= '1;
      idx_q <= '0;
      cnt_q <= '0;
      phase_q <= '0;
      taps_q <= '0;
      epoch_q <= 1'b0;
    end else begin
      st_q <= st_d;
      g1_q <= g1_d;
      g2_q <= g2_d;
      idx_q <= idx_d;
      cnt_q <= cnt_d;
      phase_q <= phase_d;
      taps_q <= taps_d;
      epoch_q <= epoch_d;
    end
  end
  assign gc_out = (st_q != ST_IDLE) & (g1_q[9] ^ g2_q[taps_q.s1] ^ g2_q[taps_q.s2]);
  assign epoch_out = epoch_q;
  assign done_out = (st_q == ST_RUN);
  assign seek_out = (st_q == ST_SEEK);
endmodule

// File: rtl/gps_ca_multi_gen.sv
// gps_ca_multi_gen: N independent C/A Gold-code channels with registered all-done / busy summaries.
module gps_ca_multi_gen
  import gps_gen_pkg::*;
#(
  parameter int N_CH     = 4,
  parameter int PHASE_W  = 16,
  parameter int SAT_W    = 5,
  parameter int CHIP_LEN = gps_gen_pkg::CHIP_LEN
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    ena_in,
  input  logic                    start_in,
  input  logic [N_CH-1:0]         chan_en_in,
  input  logic [N_CH*SAT_W-1:0]   sat_sel_in,
  input  logic [N_CH*PHASE_W-1:0] ca_phase_in,
  output logic [N_CH-1:0]         gc_out,
  output logic [N_CH-1:0]         epoch_out,
  output logic [N_CH-1:0]         phase_done_out,
  output logic                    all_done_out,
  output logic                    busy_out
);
  logic [N_CH-1:0] seek_w;
  logic all_done_q, all_done_d, busy_q, busy_d;
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    gps_ca_chan #(.PHASE_W(PHASE_W), .SAT_W(SAT_W), .CHIP_LEN(CHIP_LEN)) u_chan (
      .clk_in    (clk_in),
      .rst_in    (rst_in),
      .ena_in    (ena_in),
      .start_in  (start_in),
      .en_in     (chan_en_in[i]),
      .sat_sel_in(sat_sel_in[i*SAT_W +: SAT_W]),
      .phase_in  (ca_phase_in[i*PHASE_W +: PHASE_W]),
      .gc_out    (gc_out[i]),
      .epoch_out (epoch_out[i]),
      .done_out  (phase_done_out[i]),
      .seek_out  (seek_w[i])
    );
  end
  always_comb begin
    all_done_d = (|chan_en_in) && (&(phase_done_out | ~chan_en_in));
    busy_d = |seek_w;
  end
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      all_done_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      all_done_q <= all_done_d;
      busy_q <= busy_d;
    end
  end
  assign all_done_out = all_done_q;
  assign busy_out = busy_q;
endmodule
